// File: rtl/conv_pkg.sv
// Shared constants and FSM state type for the convolution window path.
package conv_pkg;

    localparam int unsigned SIZE_DEF      = 7;
    localparam int unsigned SIZE_KER_DEF  = 3;
    localparam int unsigned WIDTH_BIT_DEF = 8;

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_e;

endpackage

// File: rtl/conv_window_gen_if.sv
// Pixel stream in, window stream out. master drives pixels, slave produces windows.
interface conv_window_gen_if
    import conv_pkg::*;
#(
    parameter int unsigned SIZE_KER  = SIZE_KER_DEF,
    parameter int unsigned WIDTH_BIT = WIDTH_BIT_DEF
) ();

    logic                 pix_valid;
    logic [WIDTH_BIT-1:0] pix_data;
    logic                 pix_ready;
    logic [WIDTH_BIT-1:0] win [SIZE_KER][SIZE_KER];
    logic                 win_valid;
    logic                 win_ready;
    logic [WIDTH_BIT-1:0] win_row;
    logic [WIDTH_BIT-1:0] win_col;
    logic                 frame_done;

    modport master (
        output pix_valid, pix_data, win_ready,
        input  pix_ready, win, win_valid, win_row, win_col, frame_done
    );

    modport slave (
        input  pix_valid, pix_data, win_ready,
        output pix_ready, win, win_valid, win_row, win_col, frame_done
    );

endinterface

// File: rtl/line_buffer.sv
// One image row of storage: written one column at a time, every column readable in parallel.
module line_buffer #(
    parameter int unsigned SIZE      = 7,
    parameter int unsigned WIDTH_BIT = 8
) (
    input  logic                 clock,
    input  logic                 wr_en_i,
    input  logic [WIDTH_BIT-1:0] wr_col_i,
    input  logic [WIDTH_BIT-1:0] wr_data_i,
    output logic [WIDTH_BIT-1:0] rd_data_o [SIZE]
);

    localparam int N = int'(SIZE);

    logic [WIDTH_BIT-1:0] mem_q [SIZE];

    // Column write; contents are don't-care until written, so no reset.
    always_ff @(posedge clock) begin
        for (int i = 0; i < N; i++) begin
            if (wr_en_i && (wr_col_i == WIDTH_BIT'(i))) begin
                mem_q[i] <= wr_data_i;
            end
        end
    end

    assign rd_data_o = mem_q;

endmodule

// File: rtl/conv_window_gen.sv
// Sliding SIZE_KER x SIZE_KER window generator over a raster SIZE x SIZE image.
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int unsigned SIZE      = SIZE_DEF,
    parameter int unsigned SIZE_KER  = SIZE_KER_DEF,
    parameter int unsigned WIDTH_BIT = WIDTH_BIT_DEF
) (
    input logic              clock,
    input logic              nreset,
    conv_window_gen_if.slave bus
);

    localparam int          N    = int'(SIZE);
    localparam int          K    = int'(SIZE_KER);
    localparam int unsigned BufW = (SIZE_KER > 1) ? $clog2(SIZE_KER) : 1;

    typedef logic [WIDTH_BIT-1:0] pix_t;

    if (SIZE_KER > SIZE) begin : g_bad_params
        $error("conv_window_gen: SIZE_KER must not exceed SIZE");
    end

    state_e          state_q, state_d;
    pix_t            in_row_q, in_row_d, in_col_q, in_col_d;
    logic [BufW-1:0] wr_buf_q, wr_buf_d;
    pix_t            win_q [K][K];
    pix_t            win_d [K][K];
    pix_t            win_new [K][K];
    pix_t            win_row_q, win_row_d, win_col_q, win_col_d;
    logic            win_valid_q, win_valid_d;
    logic            frame_done_q, frame_done_d;
    logic            stall, pix_ready, accept, win_pix, last_col, last_row;
    pix_t            rows_all [K][N];
    pix_t            row_sel [K][N];

    for (genvar k = 0; k < K; k++) begin : g_line
        line_buffer #(
            .SIZE      (SIZE),
            .WIDTH_BIT (WIDTH_BIT)
        ) u_line (
            .clock     (clock),
            .wr_en_i   (accept && (int'(wr_buf_q) == k)),
            .wr_col_i  (in_col_q),
            .wr_data_i (bus.pix_data),
            .rd_data_o (rows_all[k])
        );
    end

    // Handshake qualifiers and position flags for the pixel being offered.
    always_comb begin
        stall     = win_valid_q && !bus.win_ready;
        pix_ready = (state_q != S_FLUSH) && !stall;
        accept    = bus.pix_valid && pix_ready;
        last_col  = (in_col_q == pix_t'(N - 1));
        last_row  = (in_row_q == pix_t'(N - 1));
        win_pix   = (int'(in_row_q) >= K - 1) && (int'(in_col_q) >= K - 1);
    end

    // Assemble the candidate window; oldest row lives in the buffer after the one being written.
    always_comb begin
        int col;
        for (int a = 0; a < K; a++) begin
            for (int i = 0; i < N; i++) begin
                row_sel[a][i] = '0;
            end
            for (int k = 0; k < K; k++) begin
                if (k == (int'(wr_buf_q) + 1 + a) % K) begin
                    row_sel[a] = rows_all[k];
                end
            end
        end
        for (int a = 0; a < K; a++) begin
            for (int b = 0; b < K; b++) begin
                win_new[a][b] = '0;
                col = int'(in_col_q) - (K - 1) + b;
                if ((a == K - 1) && (b == K - 1)) begin
                    // Newest pixel bypasses the buffer it is being written into.
                    win_new[a][b] = bus.pix_data;
                end else begin
                    for (int i = 0; i < N; i++) begin
                        if (i == col) begin
                            win_new[a][b] = row_sel[a][i];
                        end
                    end
                end
            end
        end
    end

    // Next-state: position counters, window register and frame FSM.
    always_comb begin
        state_d      = state_q;
        in_row_d     = in_row_q;
        in_col_d     = in_col_q;
        wr_buf_d     = wr_buf_q;
        win_d        = win_q;
        win_row_d    = win_row_q;
        win_col_d    = win_col_q;
        win_valid_d  = win_valid_q;
        frame_done_d = 1'b0;

        if (accept) begin
            if (last_col) begin
                in_col_d = '0;
                in_row_d = last_row ? '0 : in_row_q + pix_t'(1);
                wr_buf_d = (int'(wr_buf_q) == K - 1) ? '0 : wr_buf_q + BufW'(1);
            end else begin
                in_col_d = in_col_q + pix_t'(1);
            end
        end

        // A completing pixel may land on the same edge the previous window is consumed.
        if (accept && win_pix) begin
            win_d       = win_new;
            win_row_d   = pix_t'(int'(in_row_q) - (K - 1));
            win_col_d   = pix_t'(int'(in_col_q) - (K - 1));
            win_valid_d = 1'b1;
        end else if (win_valid_q && bus.win_ready) begin
            win_valid_d = 1'b0;
        end

        unique case (state_q)
            S_FILL: begin
                if (accept && last_col && (int'(in_row_q) == K - 2)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (accept && last_col && last_row) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (win_valid_q && bus.win_ready) begin
                    state_d      = S_FILL;
                    frame_done_d = 1'b1;
                    in_row_d     = '0;
                    in_col_d     = '0;
                    wr_buf_d     = '0;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    // State and output registers; async reset drops any partial frame.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q      <= S_FILL;
            in_row_q     <= '0;
            in_col_q     <= '0;
            wr_buf_q     <= '0;
            win_row_q    <= '0;
            win_col_q    <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            for (int a = 0; a < K; a++) begin
                for (int b = 0; b < K; b++) begin
                    win_q[a][b] <= '0;
                end
            end
        end else begin
            state_q      <= state_d;
            in_row_q     <= in_row_d;
            in_col_q     <= in_col_d;
            wr_buf_q     <= wr_buf_d;
            win_row_q    <= win_row_d;
            win_col_q    <= win_col_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
            win_q        <= win_d;
        end
    end

    assign bus.pix_ready  = pix_ready;
    assign bus.win        = win_q;
    assign bus.win_valid  = win_valid_q;
    assign bus.win_row    = win_row_q;
    assign bus.win_col    = win_col_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen with 7x7 image and 3x3 window.
module tb_conv_window_gen;
    import conv_pkg::*;

    logic clock;
    logic nreset;
    int   checks;
    int   errors;

    conv_window_gen_if #(.SIZE_KER(3), .WIDTH_BIT(8)) dut_if ();

    conv_window_gen #(
        .SIZE      (7),
        .SIZE_KER  (3),
        .WIDTH_BIT (8)
    ) dut (
        .clock  (clock),
        .nreset (nreset),
        .bus    (dut_if.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Pixel value at raster index idx: ascending ramp or descending ramp.
    function automatic logic [7:0] pval(input bit desc, input int idx);
        return desc ? 8'(48 - idx) : 8'(idx);
    endfunction

    // Drives one frame from a negedge, checking every consumed window against the raster model.
    task automatic run_frame(input bit desc, input bit toggle, input int stall_idx,
                             input int stall_len, input int stop_pix,
                             output int nwin, output int ndone);
        int pix, cyc, stalled, tail, r, c;
        bit bad, seen_first, rdy;
        logic [7:0] exp_v, got_v;
        pix = 0; cyc = 0; stalled = 0; tail = 0; nwin = 0; ndone = 0; seen_first = 0;
        while (cyc < 1000 && tail < 3 && pix < stop_pix) begin
            if (dut_if.frame_done === 1'b1) ndone++;
            if (pix == 17 && !seen_first) begin
                seen_first = 1;
                checks++;
                if (dut_if.win_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL first_win_latency: win_valid=%b required 1", dut_if.win_valid);
                end
            end
            if (pix == 49 && nwin < 25) begin
                checks++;
                if (dut_if.pix_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL flush_pix_ready: pix_ready=%b required 0", dut_if.pix_ready);
                end
            end
            rdy = 1'b1;
            if (dut_if.win_valid === 1'b1 && nwin == stall_idx && stalled < stall_len) begin
                rdy = 1'b0;
                stalled++;
            end
            dut_if.win_ready = rdy;
            dut_if.pix_valid = (pix < 49) && (!toggle || (cyc % 2 == 0));
            dut_if.pix_data  = (pix < 49) ? pval(desc, pix) : 8'd0;
            #1;
            if (!rdy) begin
                checks++;
                if (dut_if.pix_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_pix_ready: pix_ready=%b required 0", dut_if.pix_ready);
                end
            end
            if (dut_if.win_valid === 1'b1 && dut_if.win_ready) begin
                r = nwin / 5;
                c = nwin % 5;
                bad = 0; exp_v = 0; got_v = 0;
                for (int a = 0; a < 3; a++) begin
                    for (int b = 0; b < 3; b++) begin
                        if (!bad && dut_if.win[a][b] !== pval(desc, (r + a) * 7 + c + b)) begin
                            bad = 1;
                            exp_v = pval(desc, (r + a) * 7 + c + b);
                            got_v = dut_if.win[a][b];
                        end
                    end
                end
                checks++;
                if (bad || dut_if.win_row !== 8'(r) || dut_if.win_col !== 8'(c)) begin
                    errors++;
                    $display("FAIL window_%0d: got row %0d col %0d elem %0d, required row %0d col %0d elem %0d",
                             nwin, dut_if.win_row, dut_if.win_col, got_v, r, c, exp_v);
                end
                nwin++;
            end
            if (dut_if.pix_valid && dut_if.pix_ready === 1'b1) pix++;
            if (nwin == 25) tail++;
            cyc++;
            @(negedge clock);
        end
        dut_if.pix_valid = 1'b0;
        if (cyc >= 1000) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: %0d windows, %0d pixels after %0d cycles", nwin, pix, cyc);
        end
    endtask

    task automatic test_reset();
        bit nz;
        nreset = 1'b0;
        dut_if.pix_valid = 1'b0;
        dut_if.pix_data  = 8'd0;
        dut_if.win_ready = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (dut_if.win_valid !== 1'b0) begin
            errors++; $display("FAIL reset_win_valid: %b required 0", dut_if.win_valid);
        end
        checks++;
        if (dut_if.frame_done !== 1'b0) begin
            errors++; $display("FAIL reset_frame_done: %b required 0", dut_if.frame_done);
        end
        checks++;
        if (dut_if.win_row !== 8'd0 || dut_if.win_col !== 8'd0) begin
            errors++;
            $display("FAIL reset_coord: row %0d col %0d required 0 0", dut_if.win_row, dut_if.win_col);
        end
        nz = 0;
        for (int a = 0; a < 3; a++)
            for (int b = 0; b < 3; b++)
                if (dut_if.win[a][b] !== 8'd0) nz = 1;
        checks++;
        if (nz) begin
            errors++; $display("FAIL reset_win: nonzero element, required all 0");
        end
        nreset = 1'b1;
        #1;
        checks++;
        if (dut_if.pix_ready !== 1'b1) begin
            errors++; $display("FAIL reset_pix_ready: %b required 1", dut_if.pix_ready);
        end
        @(negedge clock);
    endtask

    task automatic test_ramp();
        int nwin, ndone;
        run_frame(1'b0, 1'b0, -1, 0, 1000, nwin, ndone);
        checks++;
        if (nwin != 25) begin
            errors++; $display("FAIL ramp_count: %0d windows required 25", nwin);
        end
        checks++;
        if (ndone != 1) begin
            errors++; $display("FAIL ramp_frame_done: %0d pulses required 1", ndone);
        end
    endtask

    task automatic test_stall();
        int nwin, ndone;
        run_frame(1'b0, 1'b0, 7, 5, 1000, nwin, ndone);
        checks++;
        if (nwin != 25 || ndone != 1) begin
            errors++;
            $display("FAIL stall_frame: %0d windows %0d pulses required 25 1", nwin, ndone);
        end
    endtask

    task automatic test_toggle();
        int nwin, ndone;
        run_frame(1'b0, 1'b1, -1, 0, 1000, nwin, ndone);
        checks++;
        if (nwin != 25 || ndone != 1) begin
            errors++;
            $display("FAIL toggle_frame: %0d windows %0d pulses required 25 1", nwin, ndone);
        end
    endtask

    task automatic test_reset_mid();
        int nwin, ndone;
        run_frame(1'b0, 1'b0, -1, 0, 21, nwin, ndone);
        dut_if.win_ready = 1'b1;
        #2 nreset = 1'b0;
        #1;
        checks++;
        if (dut_if.win_valid !== 1'b0 || dut_if.win_col !== 8'd0) begin
            errors++;
            $display("FAIL midreset_clear: win_valid=%b win_col=%0d required 0 0",
                     dut_if.win_valid, dut_if.win_col);
        end
        @(negedge clock);
        nreset = 1'b1;
        #1;
        checks++;
        if (dut_if.pix_ready !== 1'b1) begin
            errors++; $display("FAIL midreset_pix_ready: %b required 1", dut_if.pix_ready);
        end
        @(negedge clock);
        run_frame(1'b0, 1'b0, -1, 0, 1000, nwin, ndone);
        checks++;
        if (nwin != 25 || ndone != 1) begin
            errors++;
            $display("FAIL midreset_frame: %0d windows %0d pulses required 25 1", nwin, ndone);
        end
    endtask

    task automatic test_back_to_back();
        int nwin_a, ndone_a, nwin_b, ndone_b;
        run_frame(1'b0, 1'b0, -1, 0, 1000, nwin_a, ndone_a);
        run_frame(1'b1, 1'b0, -1, 0, 1000, nwin_b, ndone_b);
        checks++;
        if (nwin_a + nwin_b != 50) begin
            errors++; $display("FAIL b2b_count: %0d windows required 50", nwin_a + nwin_b);
        end
        checks++;
        if (ndone_a + ndone_b != 2) begin
            errors++; $display("FAIL b2b_frame_done: %0d pulses required 2", ndone_a + ndone_b);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_ramp();
        test_stall();
        test_toggle();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
